// File: rtl/wb_register_file_if.sv
// Bus bundle between the MEM/WB pipeline register, the ID stage and the
// write-back register file.
//   slave  : the register file (consumes write-back controls, drives reads)
//   master : the pipeline / environment side
// Signals:
//   RegWrite_i, MemtoReg_i, data_i, addr_i, RegDst_i : write-back request
//   RS_addr_i, RT_addr_i                              : ID-stage read addresses
//   RS_data_o, RT_data_o                              : combinational read data
//   wb_data_o                                         : selected write-back value
//   last_valid_o, last_dst_o, last_data_o             : last committed write
//   wr_count_o                                        : saturating commit counter
interface wb_register_file_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int CNT_W  = 16
);
  localparam int AW = $clog2(NREG);

  logic              RegWrite_i;
  logic              MemtoReg_i;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] addr_i;
  logic [AW-1:0]     RegDst_i;
  logic [AW-1:0]     RS_addr_i;
  logic [AW-1:0]     RT_addr_i;
  logic [DATA_W-1:0] RS_data_o;
  logic [DATA_W-1:0] RT_data_o;
  logic [DATA_W-1:0] wb_data_o;
  logic              last_valid_o;
  logic [AW-1:0]     last_dst_o;
  logic [DATA_W-1:0] last_data_o;
  logic [CNT_W-1:0]  wr_count_o;

  modport slave (
    input  RegWrite_i, MemtoReg_i, data_i, addr_i, RegDst_i, RS_addr_i, RT_addr_i,
    output RS_data_o, RT_data_o, wb_data_o, last_valid_o, last_dst_o, last_data_o,
           wr_count_o
  );

  modport master (
    output RegWrite_i, MemtoReg_i, data_i, addr_i, RegDst_i, RS_addr_i, RT_addr_i,
    input  RS_data_o, RT_data_o, wb_data_o, last_valid_o, last_dst_o, last_data_o,
           wr_count_o
  );
endinterface

// File: rtl/wb_register_file.sv
// Write-back stage register file: selects the write-back value, commits it
// to a 2-read/1-write register file, bypasses same-cycle writes to both read
// ports, records the last committed write and counts commits (saturating).
// Ports:
//   clk_i : clock, all state changes on posedge
//   rst_i : asynchronous active-high reset
//   bus   : wb_register_file_if.slave (write-back request, read ports,
//           last-commit record and commit counter)
module wb_register_file #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wb_register_file_if.slave     bus
);
  localparam int AW = $clog2(NREG);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              last_valid_q, last_valid_d;
  logic [AW-1:0]     last_dst_q,   last_dst_d;
  logic [DATA_W-1:0] last_data_q,  last_data_d;
  logic [CNT_W-1:0]  wr_count_q,   wr_count_d;

  logic              we;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  assign wb_data = bus.MemtoReg_i ? bus.data_i : bus.addr_i;
  // Register 0 is hard-wired to zero, so a write to it is not a commit.
  assign we      = bus.RegWrite_i && (bus.RegDst_i != '0);

  always_comb begin
    regs_d       = regs_q;
    last_valid_d = last_valid_q;
    last_dst_d   = last_dst_q;
    last_data_d  = last_data_q;
    wr_count_d   = wr_count_q;
    if (we) begin
      regs_d[bus.RegDst_i] = wb_data;
      last_valid_d         = 1'b1;
      last_dst_d           = bus.RegDst_i;
      last_data_d          = wb_data;
      if (wr_count_q != '1) begin
        wr_count_d = wr_count_q + 1'b1;
      end
    end
  end

  // Read ports: address 0 reads zero, a matching same-cycle commit is
  // forwarded with zero latency. The bypass is deliberately not gated by
  // reset.
  always_comb begin
    rs_data = '0;
    if (bus.RS_addr_i != '0) begin
      if (we && (bus.RegDst_i == bus.RS_addr_i)) rs_data = wb_data;
      else                                       rs_data = regs_q[bus.RS_addr_i];
    end
  end

  always_comb begin
    rt_data = '0;
    if (bus.RT_addr_i != '0) begin
      if (we && (bus.RegDst_i == bus.RT_addr_i)) rt_data = wb_data;
      else                                       rt_data = regs_q[bus.RT_addr_i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      last_valid_q <= 1'b0;
      last_dst_q   <= '0;
      last_data_q  <= '0;
      wr_count_q   <= '0;
    end else begin
      regs_q       <= regs_d;
      last_valid_q <= last_valid_d;
      last_dst_q   <= last_dst_d;
      last_data_q  <= last_data_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign bus.wb_data_o    = wb_data;
  assign bus.RS_data_o    = rs_data;
  assign bus.RT_data_o    = rt_data;
  assign bus.last_valid_o = last_valid_q;
  assign bus.last_dst_o   = last_dst_q;
  assign bus.last_data_o  = last_data_q;
  assign bus.wr_count_o   = wr_count_q;
endmodule

// File: tb/tb_wb_register_file.sv
module tb_wb_register_file;
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  wb_register_file_if #(.DATA_W(32), .NREG(32), .CNT_W(16)) bus ();
  wb_register_file_if #(.DATA_W(32), .NREG(32), .CNT_W(2))  bus_s ();

  wb_register_file #(.DATA_W(32), .NREG(32), .CNT_W(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  wb_register_file #(.DATA_W(32), .NREG(32), .CNT_W(2)) dut_sat (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: architectural state described by the behaviour rules
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [4:0]  m_dst;
  logic [31:0] m_data;
  int          m_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_valid = 1'b0;
    m_dst   = '0;
    m_data  = '0;
    m_cnt   = 0;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic w,
                                           input logic [4:0] d, input logic [31:0] v);
    if (a == 5'd0) return 32'd0;
    if (w && d != 5'd0 && d == a) return v;
    return m_regs[a];
  endfunction

  task automatic check_state(input string tag);
    check_val({tag, ".last_valid"}, {31'd0, bus.last_valid_o}, {31'd0, m_valid});
    check_val({tag, ".last_dst"},   {27'd0, bus.last_dst_o},   {27'd0, m_dst});
    check_val({tag, ".last_data"},  bus.last_data_o,           m_data);
    check_val({tag, ".wr_count"},   {16'd0, bus.wr_count_o},   (m_cnt > 65535) ? 32'd65535 : m_cnt);
  endtask

  // One bus cycle: drive, check combinational outputs before the edge,
  // advance the model on the edge, check registered outputs after it.
  task automatic apply(input string tag, input logic w, input logic mtr,
                       input logic [31:0] din, input logic [31:0] alu,
                       input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
    logic [31:0] v;
    bus.RegWrite_i = w;
    bus.MemtoReg_i = mtr;
    bus.data_i     = din;
    bus.addr_i     = alu;
    bus.RegDst_i   = dst;
    bus.RS_addr_i  = rs;
    bus.RT_addr_i  = rt;
    #1;
    v = mtr ? din : alu;
    check_val({tag, ".wb_data"}, bus.wb_data_o, v);
    check_val({tag, ".rs"},      bus.RS_data_o, exp_read(rs, w, dst, v));
    check_val({tag, ".rt"},      bus.RT_data_o, exp_read(rt, w, dst, v));
    @(posedge clk_i);
    if (w && dst != 5'd0) begin
      m_regs[dst] = v;
      m_valid     = 1'b1;
      m_dst       = dst;
      m_data      = v;
      m_cnt++;
    end
    #1;
    check_state(tag);
  endtask

  initial begin
    rst_i = 1'b1;
    bus.RegWrite_i = 0; bus.MemtoReg_i = 0; bus.data_i = '0; bus.addr_i = '0;
    bus.RegDst_i = '0; bus.RS_addr_i = 5'd5; bus.RT_addr_i = 5'd31;
    bus_s.RegWrite_i = 0; bus_s.MemtoReg_i = 0; bus_s.data_i = '0; bus_s.addr_i = '0;
    bus_s.RegDst_i = '0; bus_s.RS_addr_i = '0; bus_s.RT_addr_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_val("reset.rs5",  bus.RS_data_o, 32'd0);
    check_val("reset.rt31", bus.RT_data_o, 32'd0);
    check_state("reset");
    rst_i = 1'b0;

    apply("alu_w8",    1, 0, 32'h0,        32'h1234, 5'd8, 5'd8, 5'd5);
    apply("mem_w3",    1, 1, 32'hDEADBEEF, 32'h5,    5'd3, 5'd8, 5'd0);
    apply("rd3_both",  0, 0, 32'h0,        32'h0,    5'd0, 5'd3, 5'd3);
    apply("w0_ignore", 1, 0, 32'h0,        32'hFFFF, 5'd0, 5'd0, 5'd8);
    apply("rd0_after", 0, 0, 32'h0,        32'h0,    5'd0, 5'd0, 5'd3);
    apply("nowe_8",    0, 0, 32'h0,        32'h9999, 5'd8, 5'd8, 5'd3);
    apply("rd8_hold",  0, 1, 32'h7777,     32'h0,    5'd8, 5'd8, 5'd8);
    apply("dual_byp",  1, 1, 32'hCAFEF00D, 32'h1,    5'd31, 5'd31, 5'd31);

    for (int i = 0; i < 400; i++) begin
      logic [4:0] d, a, b;
      d = (i % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      a = $urandom_range(0, 1) ? d : 5'($urandom_range(0, 7));
      b = $urandom_range(0, 1) ? d : 5'($urandom_range(0, 31));
      apply("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, d, a, b);
    end

    // async reset between edges while a commit is being presented
    apply("pre_rst1", 1, 0, 32'h0, 32'h11, 5'd9,  5'd0, 5'd0);
    apply("pre_rst2", 1, 0, 32'h0, 32'h22, 5'd10, 5'd0, 5'd0);
    apply("pre_rst3", 1, 0, 32'h0, 32'h33, 5'd11, 5'd0, 5'd0);
    bus.RegWrite_i = 1; bus.MemtoReg_i = 0; bus.addr_i = 32'hABCD;
    bus.RegDst_i = 5'd4; bus.RS_addr_i = 5'd4; bus.RT_addr_i = 5'd10;
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    check_state("async_rst");
    check_val("async_rst.rs_bypass", bus.RS_data_o, 32'hABCD);
    check_val("async_rst.rt10",      bus.RT_data_o, 32'd0);
    @(posedge clk_i);
    #1;
    check_state("rst_no_commit");
    bus.RegWrite_i = 0; bus.RS_addr_i = 5'd4;
    #1;
    check_val("rst_no_commit.rd4", bus.RS_data_o, 32'd0);
    rst_i = 1'b0;
    apply("post_rst", 1, 1, 32'h5555AAAA, 32'h0, 5'd12, 5'd11, 5'd12);
    apply("post_rd",  0, 0, 32'h0,        32'h0, 5'd0,  5'd12, 5'd9);

    // saturating counter on the narrow-counter instance
    for (int n = 1; n <= 5; n++) begin
      bus_s.RegWrite_i = 1; bus_s.RegDst_i = 5'(n); bus_s.addr_i = 32'(n * 3);
      @(posedge clk_i);
      #1;
      check_val("sat.count", {30'd0, bus_s.wr_count_o}, (n > 3) ? 32'd3 : 32'(n));
    end
    bus_s.RegWrite_i = 0;
    check_val("sat.last_data", bus_s.last_data_o, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
